// File: rtl/adder_seq_ctrl_pkg.sv
// Shared encodings for the shift-add / restoring-divide MUL/DIV sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_seq_ctrl_pkg;

  // Sequencer states; the encoding is fixed so debug taps can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Index of the final iteration; 16 passes run with the counter at 0..15.
  localparam int LAST_ITER = 15;

endpackage

// File: rtl/adder_16bits.sv
// 16-bit add/subtract cell shared by the MUL/DIV sequencer.
// Latency: combinational.
// Backpressure: none; ctr=1 computes a-b as a+~b+1, co=1 meaning no borrow.
module adder_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ctr,
  output logic [15:0] s,
  output logic        co
);

  logic [15:0] b_eff;

  // Invert the second operand for subtraction; the carry-in supplies the +1.
  always_comb begin
    b_eff   = b ^ {16{ctr}};
    {co, s} = {1'b0, a} + {1'b0, b_eff} + {16'd0, ctr};
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Unsigned 16x16 multiply (shift-add) and 16/16 divide (restoring) on one shared adder.
// Latency: done 17 cycles after an accepted start (1 cycle for divide by zero).
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  // The datapath is hard-wired to the 16-bit adder cell.
  if (WIDTH != 16) begin : g_bad_width
    $error("adder_seq_ctrl: WIDTH must be 16 to match adder_16bits");
  end

  state_t            state, state_nxt;
  logic              op_q;
  logic [ITER_W-1:0] counter;
  logic [WIDTH-1:0]  p_hi, p_lo, m;
  logic [WIDTH-1:0]  p_hi_nxt, p_lo_nxt;
  logic [WIDTH-1:0]  add_a, add_b, add_s;
  logic              add_ctr, add_co;
  logic              div_ok;
  logic              last_iter;
  logic              start_dbz;

  assign last_iter = (counter == ITER_W'(LAST_ITER));
  assign start_dbz = (op == OP_DIV) && (b == '0);

  adder_16bits u_adder (
    .a   (add_a),
    .b   (add_b),
    .ctr (add_ctr),
    .s   (add_s),
    .co  (add_co)
  );

  // Adder operand steering and the per-iteration register update; adder held quiet outside RUN.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_ctr  = 1'b0;
    div_ok   = 1'b0;
    p_hi_nxt = p_hi;
    p_lo_nxt = p_lo;
    if (state == ST_RUN) begin
      if (op_q == OP_MUL) begin
        add_a    = p_hi;
        add_b    = p_lo[0] ? m : '0;
        p_hi_nxt = {add_co, add_s[WIDTH-1:1]};
        p_lo_nxt = {add_s[0], p_lo[WIDTH-1:1]};
      end else begin
        add_a    = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
        add_b    = m;
        add_ctr  = 1'b1;
        // A set top bit means the 17-bit partial remainder beats any divisor.
        div_ok   = p_hi[WIDTH-1] | add_co;
        p_hi_nxt = div_ok ? add_s : add_a;
        p_lo_nxt = {p_lo[WIDTH-2:0], div_ok};
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = start_dbz ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, iteration registers and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_MUL;
      counter     <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      m           <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q        <= op;
            div_by_zero <= 1'b0;
            if (start_dbz) begin
              result_lo   <= '1;
              result_hi   <= a;
              div_by_zero <= 1'b1;
            end else begin
              p_hi    <= '0;
              p_lo    <= a;
              m       <= b;
              counter <= '0;
            end
          end
        end
        ST_RUN: begin
          p_hi    <= p_hi_nxt;
          p_lo    <= p_lo_nxt;
          counter <= counter + ITER_W'(1);
          // Results must already be valid in the done cycle, so take the final pass directly.
          if (last_iter) begin
            result_lo <= p_lo_nxt;
            result_hi <= p_hi_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: directed corner cases plus random MUL/DIV traffic.
// Latency: checks done at 17 cycles (1 for divide by zero) and 16 busy cycles.
// Backpressure: checks that starts during RUN/DONE are dropped and reset aborts cleanly.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result_lo, result_hi;
  logic        div_by_zero;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_seen = 0;
  int pushed    = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  adder_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [32:0] model(input logic o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    if (o == 1'b0) begin
      p = 32'(x) * 32'(y);
      return {1'b0, p};
    end else if (y == 16'd0) begin
      return {1'b1, x, 16'hFFFF};
    end else begin
      return {1'b0, x % y, x / y};
    end
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL spurious_done: got done=1 with no operation outstanding, required none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_lo", 32'(result_lo), 32'(mon_e[15:0]));
        chk("result_hi", 32'(result_hi), 32'(mon_e[31:16]));
        chk("div_by_zero", 32'(div_by_zero), 32'(mon_e[32]));
      end
    end
  end

  // Issue one operation; optionally pulse a stray start at cycle inj or in the done cycle.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        input int inj, input bit inj_done);
    int lat  = 0;
    int bcnt = 0;
    bit got  = 0;
    bit dbz;
    dbz = (o == 1'b1) && (y == 16'd0);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(model(o, x, y));
    pushed++;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1;
        lat = k;
      end else begin
        start = (k == inj);
        if (k == inj) begin
          a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
        end
      end
    end
    chk("done_latency", 32'(lat), dbz ? 32'd1 : 32'd17);
    chk("busy_cycles", 32'(bcnt), dbz ? 32'd0 : 32'd16);
    if (inj_done) begin
      start = 1'b1; a = 16'($urandom); b = 16'h0001; op = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_busy", 32'(busy), 32'd0);
      chk("start_in_done_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lo", 32'(result_lo), 32'd0);
    chk("rst_hi", 32'(result_hi), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 16'd3, 16'd5, 0, 0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
    run_op(1'b0, 16'h1234, 16'h0000, 0, 0);
    run_op(1'b1, 16'd100, 16'd7, 0, 0);
    run_op(1'b1, 16'hFFFF, 16'h0001, 0, 0);
    run_op(1'b1, 16'h8000, 16'hFFFF, 0, 0);
    run_op(1'b1, 16'h00AB, 16'h0000, 0, 0);
    run_op(1'b1, 16'd100, 16'd7, 0, 0);
    run_op(1'b0, 16'h0102, 16'h0304, 5, 1);

    // Abort mid-run: no done may follow for this operation.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'hBEEF; b = 16'h1357;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_lo", 32'(result_lo), 32'd0);
    chk("abort_hi", 32'(result_hi), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run_op(1'b0, 16'd6, 16'd7, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic        ro;
      logic [15:0] rx, ry;
      ro = 1'($urandom);
      rx = 16'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) ry = 16'($urandom_range(1, 15));
      run_op(ro, rx, ry, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0,
             1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(pushed));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Multi-cycle sequencer that time-shares one `adder_16bits` instance to perform two operations on 16-bit operands:
  - unsigned 16x16 multiply, by shift-add;
  - unsigned 16/16 divide, by restoring division.
- Sits beside the ALU as the MUL/DIV unit and uses a start/busy/done handshake.
- One add or subtract pass is made per clock, for exactly 16 iterations.

Parameters:
- WIDTH, 16, operand width. Fixed at 16 to match `adder_16bits`; any other value is a compile-time error.
- ITER_W, 5, width of the iteration counter (counts 0..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  1  0 = multiply, 1 = divide; sampled with start
- a  in  16  multiplicand (mul) / dividend (div); sampled with start
- b  in  16  multiplier (mul) / divisor (div); sampled with start
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse when results are valid
- result_lo  out  16  mul: product[15:0]; div: quotient
- result_hi  out  16  mul: product[31:16]; div: remainder
- div_by_zero  out  1  set on a divide with b==0; held with the results

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - State = IDLE; busy = 0; done = 0.
  - result_lo = result_hi = 0; div_by_zero = 0; counter = 0.
  - Internal registers P_hi, P_lo, M are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op, a and b, and clears div_by_zero.
  - Divide with b==0: go directly to DONE with result_lo=16'hFFFF, result_hi=a, div_by_zero=1.
  - Otherwise go to RUN with counter=0.
  - Multiply load: P_hi=0, P_lo=a, M=b.
  - Divide load: P_hi=0 (remainder), P_lo=a (quotient/dividend), M=b.
- RUN, one iteration per cycle:
  - Multiply:
    - Adder inputs: A=P_hi, B = P_lo[0] ? M : 0, Ctr=0.
    - Update: P_hi <= {Co, S[15:1]}; P_lo <= {S[0], P_lo[15:1]}.
  - Divide:
    - Adder inputs: A = {P_hi[14:0], P_lo[15]}, B=M, Ctr=1 (subtract).
    - ok = P_hi[15] | Co. Co=1 means no borrow; P_hi[15]=1 means the 17-bit partial remainder exceeds any divisor.
    - Update: P_hi <= ok ? S : A; P_lo <= {P_lo[14:0], ok}.
  - counter increments every cycle; when counter==15, go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - result_lo and result_hi are loaded from P_lo and P_hi on entry to DONE (div-by-zero path excepted).
  - Unconditional transition to IDLE.
- Output timing:
  - busy = (state==RUN).
  - Results and div_by_zero hold their value until the next accepted start.
- Latency, with start sampled at edge T:
  - busy is high for cycles T+1..T+16.
  - done is high at cycle T+17.
  - Divide-by-zero: done at T+1, busy never asserts.
- Ignored requests: start during RUN or DONE is ignored (no queueing). Inputs a, b and op are don't-care outside the IDLE start cycle.
- Reset mid-operation: aborts immediately to IDLE with the reset values above; no done pulse.
- Idle adder drive: when not in RUN, drive the adder with A=0, B=0, Ctr=0 so it does not toggle.
- Arithmetic: all operations are unsigned; there is no overflow, since the product is the full 32 bits.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - OP_MUL=1'b0, OP_DIV=1'b1;
  - LAST_ITER=15.
- One sub-module: the existing `adder_16bits`, instantiated once. No second adder and no behavioural '+' or '-' on the datapath.
- The only other arithmetic is the counter increment.

Test Plan:
- Small multiply: reset, then start op=0 a=3 b=5 → busy for 16 cycles, done at T+17, result_hi=0x0000 result_lo=0x000F, div_by_zero=0.
- Full-width multiply: op=0 a=0xFFFF b=0xFFFF → result_hi=0xFFFE result_lo=0x0001. Also op=0 a=0x1234 b=0 → result 0x0000_0000.
- Divides:
  - op=1 a=100 b=7 → result_lo=14 result_hi=2.
  - op=1 a=0xFFFF b=1 → result_lo=0xFFFF result_hi=0.
  - op=1 a=0x8000 b=0xFFFF → result_lo=0 result_hi=0x8000.
- Divide by zero: op=1 a=0x00AB b=0 → done at T+1, busy stays 0, result_lo=0xFFFF result_hi=0x00AB div_by_zero=1. A following valid divide clears div_by_zero.
- Start while busy: during RUN assert start with different operands at T+5 → ignored, first result unchanged, exactly one done pulse. Start asserted in the DONE cycle is also ignored.
- Reset mid-run:
  - Assert rst at T+8 → next cycle state IDLE, busy=0, done=0, results=0, and done never pulses for the aborted operation.
  - A new start op=0 a=6 b=7 then completes with result_lo=42.
